// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e  : mul/div occupancy FSM states (RUN, MD_WAIT)
//   REG_W    : register-specifier width
//   REG_ZERO : the hard-wired zero register, which never creates a dependency
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN,
        MD_WAIT
    } state_e;

    localparam int unsigned         REG_W    = 5;
    localparam logic [REG_W-1:0]    REG_ZERO = '0;

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the 5-stage pipeline and the hazard controller.
//   master : pipeline side; drives the stage-tagged register IDs and hazard
//            sources, receives the write-enables, flushes and Busy.
//   slave  : hazard controller side.
// Optional (HAZARD_STATS_EN): StallCount / FlushCount performance counters.
interface hazard_unit_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] RsIF2ID;
    logic [REG_W-1:0] RtIF2ID;
    logic [REG_W-1:0] RtID2EX;
    logic             MemReadID2EX;
    logic             BranchTakenID;
    logic             JumpID;
    logic             MulDivStartID2EX;

    logic             PCWrite;
    logic             IF2IDWrite;
    logic             IF2IDFlush;
    logic             ID2EXWrite;
    logic             ID2EXFlush;
    logic             Busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]      StallCount;
    logic [31:0]      FlushCount;
`endif

    modport master (
        output RsIF2ID, RtIF2ID, RtID2EX, MemReadID2EX, BranchTakenID, JumpID,
               MulDivStartID2EX,
        input  PCWrite, IF2IDWrite, IF2IDFlush, ID2EXWrite, ID2EXFlush, Busy
`ifdef HAZARD_STATS_EN
        , input StallCount, FlushCount
`endif
    );

    modport slave (
        input  RsIF2ID, RtIF2ID, RtID2EX, MemReadID2EX, BranchTakenID, JumpID,
               MulDivStartID2EX,
        output PCWrite, IF2IDWrite, IF2IDFlush, ID2EXWrite, ID2EXFlush, Busy
`ifdef HAZARD_STATS_EN
        , output StallCount, FlushCount
`endif
    );

endinterface

// File: rtl/md_stall_timer.sv
// Mul/div occupancy timer: tracks how long a multi-cycle op holds EX.
//   clk   : core clock
//   rst   : synchronous active-high reset (returns to RUN, clears count)
//   start : mul/div entering EX this cycle
//   busy  : high while in MD_WAIT (pipeline frozen); low while rst is high
// A start in RUN freezes the pipe for MD_LATENCY-1 following cycles.
module md_stall_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            RUN: begin
                // Single-cycle ops finish within the entry cycle: no freeze.
                if (start && (MD_LATENCY > 1)) begin
                    state_d = MD_WAIT;
                    count_d = CNT_W'(MD_LATENCY - 2);
                end
            end
            MD_WAIT: begin
                if (count_q == '0) begin
                    state_d = RUN;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                count_d = '0;
            end
        endcase
    end

    assign busy = (state_q == MD_WAIT) && !rst;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller for the 5-stage core. Handles load-use
// hazards, taken branch/jump redirects resolved in ID, and mul/div EX
// occupancy.
//   clk : core clock
//   rst : synchronous active-high reset; outputs forced to the no-hazard values
//   hz  : hazard_unit_if.slave - register IDs and hazard sources in,
//         PC / IF/ID / ID/EX enables and flushes plus Busy out
// Optional macro HAZARD_STATS_EN adds saturating StallCount / FlushCount.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);

    logic busy;
    logic load_use;
    logic redirect;

    md_stall_timer #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_stall_timer (
        .clk   (clk),
        .rst   (rst),
        .start (hz.MulDivStartID2EX),
        .busy  (busy)
    );

    assign load_use = hz.MemReadID2EX && (hz.RtID2EX != REG_ZERO) &&
                      ((hz.RtID2EX == hz.RsIF2ID) || (hz.RtID2EX == hz.RtIF2ID));
    assign redirect = hz.BranchTakenID || hz.JumpID;

    always_comb begin
        hz.PCWrite    = 1'b1;
        hz.IF2IDWrite = 1'b1;
        hz.IF2IDFlush = 1'b0;
        hz.ID2EXWrite = 1'b1;
        hz.ID2EXFlush = 1'b0;
        hz.Busy       = busy;
        if (!rst) begin
            if (busy) begin
                // Frozen pipe: ID-stage hazards are re-evaluated once it thaws.
                hz.PCWrite    = 1'b0;
                hz.IF2IDWrite = 1'b0;
                hz.ID2EXWrite = 1'b0;
            end else if (load_use) begin
                // Redirect waits a cycle so the branch sees the forwarded load data.
                hz.PCWrite    = 1'b0;
                hz.IF2IDWrite = 1'b0;
                hz.ID2EXFlush = 1'b1;
            end else if (redirect) begin
                hz.IF2IDFlush = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!hz.PCWrite && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (hz.IF2IDFlush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if hz ();

    hazard_unit #(
        .MD_LATENCY (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct packed {
        logic       r;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rtex;
        logic       mr;
        logic       br;
        logic       j;
        logic       md;
        logic [5:0] exp;
    } vec_t;

    // {PCWrite, IF2IDWrite, IF2IDFlush, ID2EXWrite, ID2EXFlush, Busy}
    localparam logic [5:0] E_RUN   = 6'b110100;
    localparam logic [5:0] E_STALL = 6'b000110;
    localparam logic [5:0] E_REDIR = 6'b111100;
    localparam logic [5:0] E_WAIT  = 6'b000001;

    logic [5:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rtex, input logic mr, input logic br,
                                input logic j, input logic md, input logic [5:0] exp);
        vec_t v;
        v = '{r: r, rs: rs, rt: rt, rtex: rtex, mr: mr, br: br, j: j, md: md, exp: exp};
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {hz.PCWrite, hz.IF2IDWrite, hz.IF2IDFlush, hz.ID2EXWrite, hz.ID2EXFlush, hz.Busy};
    endfunction

    // Apply one cycle of stimulus and record its expected response.
    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst                 = v.r;
        hz.RsIF2ID          = v.rs;
        hz.RtIF2ID          = v.rt;
        hz.RtID2EX          = v.rtex;
        hz.MemReadID2EX     = v.mr;
        hz.BranchTakenID    = v.br;
        hz.JumpID           = v.j;
        hz.MulDivStartID2EX = v.md;
        exp_q.push_back(v.exp);
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t tbl[4] = '{
            mk(1, 8, 8, 8, 1, 1, 0, 1, E_RUN),   // everything asserted, rst wins
            mk(1, 8, 8, 8, 1, 0, 1, 1, E_RUN),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),   // no MD_WAIT left behind
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN)
        };
        logic [5:0] got, want;
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t tbl[6] = '{
            mk(0, 8, 3, 8, 1, 0, 0, 0, E_STALL), // rs match
            mk(0, 8, 3, 8, 0, 0, 0, 0, E_RUN),   // bubble cleared MemRead
            mk(0, 2, 17, 17, 1, 0, 0, 0, E_STALL), // rt match
            mk(0, 2, 17, 17, 0, 0, 0, 0, E_RUN),
            mk(0, 8, 9, 7, 1, 0, 0, 0, E_RUN),   // load to unrelated reg
            mk(0, 8, 9, 8, 0, 0, 0, 0, E_RUN)    // match but not a load
        };
        logic [5:0] got, want;
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL load_use[%0d]: got %b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_zero_reg();
        vec_t tbl[2] = '{
            mk(0, 0, 0, 0, 1, 0, 0, 0, E_RUN),
            mk(0, 5, 0, 0, 1, 0, 0, 0, E_RUN)
        };
        logic [5:0] got, want;
        for (int i = 0; i < 2; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL zero_reg[%0d]: got %b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_redirect();
        vec_t tbl[5] = '{
            mk(0, 4, 9, 9, 1, 1, 0, 0, E_STALL), // load-use beats branch
            mk(0, 4, 9, 9, 0, 1, 0, 0, E_REDIR),
            mk(0, 0, 0, 0, 0, 0, 1, 0, E_REDIR), // jump
            mk(0, 6, 1, 6, 1, 0, 1, 0, E_STALL), // load-use beats jump
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN)
        };
        logic [5:0] got, want;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL redirect[%0d]: got %b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t tbl[10] = '{
            mk(0, 0, 0, 0, 0, 0, 0, 1, E_RUN),   // entry cycle advances
            mk(0, 8, 3, 8, 1, 1, 0, 0, E_WAIT),  // hazards ignored while frozen
            mk(0, 0, 0, 0, 0, 0, 1, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),
            mk(0, 8, 3, 8, 1, 0, 0, 1, E_STALL), // start together with load-use
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN)
        };
        logic [5:0] got, want;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL muldiv[%0d]: got %b, expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t tbl[10] = '{
            mk(0, 0, 0, 0, 0, 0, 0, 1, E_RUN),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(1, 8, 8, 8, 1, 0, 0, 0, E_RUN),   // rst in second wait cycle
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),
            mk(0, 0, 0, 0, 0, 0, 0, 1, E_RUN),   // fresh start: full freeze
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN)
        };
        logic [5:0] got, want;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid_wait[%0d]: got %b, expected %b", i, got, want);
            end
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        vec_t tbl[10] = '{
            mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN),
            mk(0, 8, 3, 8, 1, 0, 0, 0, E_STALL),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN),
            mk(0, 2, 5, 5, 1, 0, 0, 0, E_STALL),
            mk(0, 0, 0, 0, 0, 0, 1, 0, E_REDIR),
            mk(0, 0, 0, 0, 0, 0, 0, 1, E_RUN),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_WAIT),
            mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN)
        };
        logic [5:0] got, want;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            got  = outs();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL stats_seq[%0d]: got %b, expected %b", i, got, want);
            end
        end
        n_vec++;
        if (hz.StallCount !== 32'd5) begin
            n_err++;
            $display("FAIL stall_count: got %0d, expected 5", hz.StallCount);
        end
        n_vec++;
        if (hz.FlushCount !== 32'd1) begin
            n_err++;
            $display("FAIL flush_count: got %0d, expected 1", hz.FlushCount);
        end
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        void'(exp_q.pop_front());
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        void'(exp_q.pop_front());
        n_vec++;
        if (hz.StallCount !== 32'd0 || hz.FlushCount !== 32'd0) begin
            n_err++;
            $display("FAIL stats_clear: got %0d/%0d, expected 0/0",
                     hz.StallCount, hz.FlushCount);
        end
    endtask
`endif

    initial begin
        rst                 = 1'b1;
        hz.RsIF2ID          = '0;
        hz.RtIF2ID          = '0;
        hz.RtID2EX          = '0;
        hz.MemReadID2EX     = 1'b0;
        hz.BranchTakenID    = 1'b0;
        hz.JumpID           = 1'b0;
        hz.MulDivStartID2EX = 1'b0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_redirect();
        test_muldiv();
        test_reset_mid_wait();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline stall/flush controller for the 5-stage MIPS core; the counterpart to operand forwarding.
- Covers what bypassing cannot: load-use hazards, branch/jump redirects in ID, and multi-cycle mul/div occupancy of EX.
- Drives PC, IF/ID and ID/EX write-enables and flushes.
- Sits beside the pipeline registers and consumes the same stage-tagged register IDs.

Parameters:
- MD_LATENCY, 4, total EX cycles for a mul/div op (≥1); the pipeline is frozen for MD_LATENCY-1 cycles.
- CNT_W, $clog2(MD_LATENCY+1), width of the mul/div down-counter.

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- RsIF2ID  in  5  rs field of the instruction in ID.
- RtIF2ID  in  5  rt field of the instruction in ID.
- RtID2EX  in  5  destination rt of the instruction in EX.
- MemReadID2EX  in  1  instruction in EX is a load.
- BranchTakenID  in  1  branch resolved taken in ID.
- JumpID  in  1  j/jal/jr in ID.
- MulDivStartID2EX  in  1  mul/div entering EX this cycle.
- PCWrite  out  1  PC load enable.
- IF2IDWrite  out  1  IF/ID register load enable.
- IF2IDFlush  out  1  zero IF/ID (squash fetched instruction).
- ID2EXWrite  out  1  ID/EX register load enable.
- ID2EXFlush  out  1  insert bubble (zero control) into ID/EX.
- Busy  out  1  high while in MD_WAIT.

Behaviour:
- States: RUN, MD_WAIT. Registered state plus count[CNT_W-1:0]. All outputs are combinational from state and inputs.
- Reset: while rst=1 at an edge, the next state is RUN and count=0. While rst=1, outputs are forced to PCWrite=1, IF2IDWrite=1, ID2EXWrite=1, flushes=0, Busy=0. The same values apply in RUN with no hazard.
- Load-use (RUN): loaduse = MemReadID2EX && RtID2EX!=0 && (RtID2EX==RsIF2ID || RtID2EX==RtIF2ID).
  - Response: PCWrite=0, IF2IDWrite=0, ID2EXFlush=1, in the same cycle.
  - Exactly one bubble. The next cycle re-evaluates naturally, because the bubble clears MemReadID2EX.
- Redirect (RUN): BranchTakenID||JumpID with no load-use gives IF2IDFlush=1; PC takes the target (PCWrite=1).
  - Load-use has priority: IF2IDFlush=0 and the redirect is re-evaluated next cycle with the forwarded value.
- Mul/div entry (RUN): MulDivStartID2EX=1 && MD_LATENCY>1 → next state MD_WAIT, count=MD_LATENCY-2.
  - The entry cycle itself advances normally.
  - MD_LATENCY=1 never leaves RUN.
- MD_WAIT:
  - PCWrite=0, IF2IDWrite=0, ID2EXWrite=0, Busy=1, flushes=0.
  - Load-use and redirect inputs are ignored (the pipe is frozen).
  - count==0 → RUN next edge; else count-1.
  - Total freeze = MD_LATENCY-1 cycles.
- Simultaneous MulDivStartID2EX and load-use in RUN: the load-use response applies this cycle, and the MD_WAIT transition is also taken. The EX-stage op is independent of the ID bubble.
- Reset mid-MD_WAIT: RUN on that edge; counter cleared; no residual stall.
- Register 0 never causes a stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs StallCount (32) and FlushCount (32).
  - StallCount increments each cycle PCWrite=0.
  - FlushCount increments each cycle IF2IDFlush=1.
  - Both clear on rst and saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, MD_WAIT}.
  - REG_ZERO=5'd0.
  - REG_W=5.
- Sub-module md_stall_timer: the down-counter and MD_WAIT FSM.
  - Inputs: start, rst.
  - Output: busy.
- Load-use and redirect logic stays in hazard_unit.

Test Plan:
- Load-use: MemReadID2EX=1, RtID2EX=8, RsIF2ID=8 → PCWrite=0, IF2IDWrite=0, ID2EXFlush=1 for one cycle. Next cycle with MemReadID2EX=0 → all enables 1.
- Zero register: MemReadID2EX=1, RtID2EX=0, RtIF2ID=0 → no stall, PCWrite=1.
- Branch vs load-use: BranchTakenID=1 with load-use on RtIF2ID=9 → IF2IDFlush=0, stall. Next cycle with no load-use → IF2IDFlush=1.
- Mul/div, MD_LATENCY=4: MulDivStartID2EX pulse at cycle t → Busy=1 and PCWrite=IF2IDWrite=ID2EXWrite=0 for cycles t+1..t+3; RUN at t+4.
- Reset mid-wait: rst=1 at the second MD_WAIT cycle → next cycle Busy=0, enables 1, count=0. A new start behaves normally.
- HAZARD_STATS_EN: 2 load-use stalls + 1 jump flush + one 4-cycle mul/div → StallCount=5, FlushCount=1. rst → both 0.
